// File: rtl/fp_mul_arbiter_if.sv
// Bundle of the request, multiplier and response signals of fp_mul_arbiter.
// slave: the arbiter's view. master: the environment's view (requesters,
// multiplier and response consumer).
interface fp_mul_arbiter_if;
    logic        req0_valid;
    logic        req1_valid;
    logic        req0_ready;
    logic        req1_ready;
    logic [31:0] req0_x;
    logic [31:0] req0_y;
    logic [31:0] req1_x;
    logic [31:0] req1_y;
    logic [2:0]  req0_rmode;
    logic [2:0]  req1_rmode;

    logic [31:0] mul_x;
    logic [31:0] mul_y;
    logic [2:0]  mul_rmode;
    logic [31:0] mul_z;
    logic        mul_ovrf;
    logic        mul_udrf;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_z;
    logic        rsp_ovrf;
    logic        rsp_udrf;

    logic        flags_clr;
    logic        sticky_ovrf;
    logic        sticky_udrf;
    logic        busy;

    modport slave (
        input  req0_valid, req1_valid, req0_x, req0_y, req1_x, req1_y,
        input  req0_rmode, req1_rmode,
        output req0_ready, req1_ready,
        output mul_x, mul_y, mul_rmode,
        input  mul_z, mul_ovrf, mul_udrf,
        output rsp_valid, rsp_id, rsp_z, rsp_ovrf, rsp_udrf,
        input  rsp_ready, flags_clr,
        output sticky_ovrf, sticky_udrf, busy
    );

    modport master (
        output req0_valid, req1_valid, req0_x, req0_y, req1_x, req1_y,
        output req0_rmode, req1_rmode,
        input  req0_ready, req1_ready,
        input  mul_x, mul_y, mul_rmode,
        output mul_z, mul_ovrf, mul_udrf,
        input  rsp_valid, rsp_id, rsp_z, rsp_ovrf, rsp_udrf,
        output rsp_ready, flags_clr,
        input  sticky_ovrf, sticky_udrf, busy
    );
endinterface

// File: rtl/fp_mul_arbiter.sv
// Two-requester arbiter in front of a combinational fp multiplier.
// Grant -> operands registered (EXEC) -> result registered (HOLD) -> handshake.
// A new grant may coincide with the HOLD handshake, giving one op every 2 cycles.
module fp_mul_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    fp_mul_arbiter_if.slave   arb_io
);

    typedef enum logic [1:0] {StIdle, StExec, StHold} state_e;

    state_e      state_q;
    logic        rr_q;
    logic [31:0] op_x_q;
    logic [31:0] op_y_q;
    logic [2:0]  op_rmode_q;
    logic        op_id_q;
    logic        rsp_id_q;
    logic [31:0] rsp_z_q;
    logic        rsp_ovrf_q;
    logic        rsp_udrf_q;
    logic        sticky_ovrf_q;
    logic        sticky_udrf_q;
    logic        sticky_ovrf_d;
    logic        sticky_udrf_d;

    logic        accept;
    logic        sel;
    logic        grant;

    // Requester selection and grant; rst_n gating keeps ready low during reset.
    always_comb begin
        accept = (state_q == StIdle) || ((state_q == StHold) && arb_io.rsp_ready);
        if (arb_io.req0_valid && arb_io.req1_valid) begin
            sel = RR_EN ? rr_q : 1'b0;
        end else begin
            sel = arb_io.req1_valid;
        end
        grant = rst_n && accept && (arb_io.req0_valid || arb_io.req1_valid);
    end

    // Sticky flags: clear first, then OR in the capture so a coincident set wins.
    always_comb begin
        sticky_ovrf_d = arb_io.flags_clr ? 1'b0 : sticky_ovrf_q;
        sticky_udrf_d = arb_io.flags_clr ? 1'b0 : sticky_udrf_q;
        if (state_q == StExec) begin
            sticky_ovrf_d = sticky_ovrf_d | arb_io.mul_ovrf;
            sticky_udrf_d = sticky_udrf_d | arb_io.mul_udrf;
        end
    end

    // Control FSM with operand, response and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            rr_q          <= 1'b0;
            op_x_q        <= '0;
            op_y_q        <= '0;
            op_rmode_q    <= '0;
            op_id_q       <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_z_q       <= '0;
            rsp_ovrf_q    <= 1'b0;
            rsp_udrf_q    <= 1'b0;
            sticky_ovrf_q <= 1'b0;
            sticky_udrf_q <= 1'b0;
        end else begin
            sticky_ovrf_q <= sticky_ovrf_d;
            sticky_udrf_q <= sticky_udrf_d;
            if (grant) begin
                op_x_q     <= sel ? arb_io.req1_x : arb_io.req0_x;
                op_y_q     <= sel ? arb_io.req1_y : arb_io.req0_y;
                op_rmode_q <= sel ? arb_io.req1_rmode : arb_io.req0_rmode;
                op_id_q    <= sel;
                rr_q       <= ~sel;
            end
            unique case (state_q)
                StIdle: begin
                    if (grant) state_q <= StExec;
                end
                StExec: begin
                    rsp_id_q   <= op_id_q;
                    rsp_z_q    <= arb_io.mul_z;
                    rsp_ovrf_q <= arb_io.mul_ovrf;
                    rsp_udrf_q <= arb_io.mul_udrf;
                    state_q    <= StHold;
                end
                StHold: begin
                    if (arb_io.rsp_ready) state_q <= grant ? StExec : StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign arb_io.req0_ready  = grant && !sel;
    assign arb_io.req1_ready  = grant && sel;
    assign arb_io.mul_x       = op_x_q;
    assign arb_io.mul_y       = op_y_q;
    assign arb_io.mul_rmode   = op_rmode_q;
    assign arb_io.rsp_valid   = (state_q == StHold);
    assign arb_io.rsp_id      = rsp_id_q;
    assign arb_io.rsp_z       = rsp_z_q;
    assign arb_io.rsp_ovrf    = rsp_ovrf_q;
    assign arb_io.rsp_udrf    = rsp_udrf_q;
    assign arb_io.sticky_ovrf = sticky_ovrf_q;
    assign arb_io.sticky_udrf = sticky_udrf_q;
    assign arb_io.busy        = (state_q != StIdle);

endmodule

// File: doc/fp_mul_arbiter.md
FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1, meaning 1 = round-robin between requesters and 0 = fixed priority to requester 0.
REQ-002 The block SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 The block SHALL have ports req0_valid / req1_valid  in  1 each  operand request valid.
REQ-005 The block SHALL have ports req0_ready / req1_ready  out  1 each  request accepted this cycle.
REQ-006 The block SHALL have ports req0_x, req0_y / req1_x, req1_y  in  32 each  IEEE-754 single operands.
REQ-007 The block SHALL have ports req0_rmode / req1_rmode  in  3 each  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
REQ-008 The block SHALL have ports mul_x, mul_y  out  32 each  operands driven to the combinational fp multiplier.
REQ-009 The block SHALL have port mul_rmode  out  3  rounding mode driven to the multiplier.
REQ-010 The block SHALL have port mul_z  in  32  multiplier result.
REQ-011 The block SHALL have ports mul_ovrf, mul_udrf  in  1 each  multiplier overflow and underflow flags.
REQ-012 The block SHALL have ports rsp_valid  out  1  result valid, and rsp_ready  in  1  consumer accepts result.
REQ-013 The block SHALL have ports rsp_id  out  1  requester index of the result, and rsp_z  out  32  result.
REQ-014 The block SHALL have ports rsp_ovrf, rsp_udrf  out  1 each  per-result exception flags.
REQ-015 The block SHALL have ports flags_clr  in  1, sticky_ovrf / sticky_udrf  out  1 each, and busy  out  1.

Function
REQ-016 The FSM SHALL have three states: IDLE (no operation), EXEC (operands applied to multiplier), HOLD (result presented).
REQ-017 The block SHALL accept a request in IDLE, or in HOLD on a cycle with rsp_valid && rsp_ready; the accepting cycle is the grant cycle.
REQ-018 Requester selection: one valid -> that requester; both valid with RR_EN=1 -> the requester indicated by the RR pointer; both valid with RR_EN=0 -> requester 0.
REQ-019 The RR pointer SHALL reset to 0 and, after each grant to requester k, point to requester 1-k.
REQ-020 reqk_ready SHALL be combinational, high only for the selected requester in an accepting cycle; at most one ready high per cycle.
REQ-021 On grant the block SHALL register x, y, rmode and id into operand registers and enter EXEC.
REQ-022 mul_x, mul_y and mul_rmode SHALL be driven from the operand registers at all times; they hold their last values outside EXEC.
REQ-023 In EXEC the block SHALL capture mul_z, mul_ovrf, mul_udrf and the id into rsp registers and enter HOLD; latency is grant at cycle N -> rsp_valid at N+2.
REQ-024 In HOLD, rsp_valid SHALL be 1 and rsp_id, rsp_z and flags SHALL stay stable until rsp_ready; on handshake -> EXEC if a grant occurs in the same cycle, else IDLE.
REQ-025 HOLD with rsp_ready=0 SHALL force both reqk_ready to 0.
REQ-026 sticky_ovrf/udrf SHALL OR in the captured flags at the EXEC capture; flags_clr clears them; simultaneous set and clear -> set wins.
REQ-027 busy SHALL equal (state != IDLE).
REQ-028 A requester holding valid SHALL keep its operands stable until ready; valid SHALL NOT depend on ready.

Reset
REQ-029 While rst_n=0: state IDLE, RR pointer 0, operand/rsp registers 0, and all outputs 0 (including mul_x, mul_y, mul_rmode, rsp_*, sticky_*, busy, reqk_ready), asserted asynchronously.
REQ-030 A reset during EXEC or HOLD SHALL discard the in-flight operation; no response is produced after release.

Verification
REQ-031 req0 0x40400000*0x40400000, rmode 001, grant cycle 0 -> rsp_valid cycle 2, rsp_id 0, rsp_z 0x41100000, flags 0.
REQ-032 RR_EN=1, both valid continuously, rsp_ready=1 -> grant order 0,1,0,1; rsp_id sequence 0,1,0,1; one grant every 2 cycles after the first.
REQ-033 rsp_ready=0 for 5 cycles in HOLD -> rsp outputs constant, both ready 0; on rsp_ready=1 a pending request is granted in the same cycle.
REQ-034 0x7f000000*0x7f000000 -> rsp_ovrf 1, sticky_ovrf 1 held until flags_clr; flags_clr coincident with a new overflow capture -> sticky_ovrf stays 1.
REQ-035 rst_n low during EXEC -> outputs 0 immediately; after release, no rsp_valid until a new grant.
REQ-036 RR_EN=0, both valid continuously -> every grant goes to req0; req1_ready stays 0.
